// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage valid/ready piecewise-linear sigmoid/tanh unit built on a shared
// 2^-|x| term. Each stage's payload is held until the stage downstream can take it.
module sigmoid_pwl_pipe #(
  parameter int IW = 8,
  parameter int FW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW+FW-1:0] in_x,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FW:0]      out_y,
  output logic             out_clip
);
  localparam int W = IW + FW;
  localparam logic [W-1:0]  XMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  XMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [FW-1:0] HALF = {1'b1, {(FW-1){1'b0}}};

  typedef struct packed {
    logic mode;
    logic neg;
    logic clip;
  } tag_t;

  logic [3:1]    vld_q, vld_d;
  logic [3:1]    adv, ld;
  // Stage 1 keeps only a>>2: the core term never looks at the two LSBs of |x2|.
  logic [W-3:0]  a1_q, a1_d;
  tag_t          tag1_q, tag1_d;
  logic [FW-1:0] t2_q, t2_d;
  tag_t          tag2_q, tag2_d;
  logic [FW:0]   y3_q, y3_d;
  logic          clip3_q, clip3_d;

  // stage 1 combinational results
  logic [W-1:0]  x2;
  logic          sat2, sat_abs;
  logic [W-3:0]  s1_a;
  // stage 2 / 3 combinational results
  logic [IW-2:0] n;
  logic [FW-1:0] base, s2_t, s;
  logic [FW:0]   s3_y;

  always_comb begin
    adv[3] = !vld_q[3] || out_ready;
    adv[2] = !vld_q[2] || adv[3];
    adv[1] = !vld_q[1] || adv[2];
    ld     = {3{ena}} & adv;
  end

  assign in_ready  = ena && adv[1];
  assign out_valid = ena && vld_q[3];
  assign out_y     = y3_q;
  assign out_clip  = clip3_q;

  always_comb begin
    sat2 = in_mode && (in_x[W-1] != in_x[W-2]);
    if (!in_mode)  x2 = in_x;
    else if (sat2) x2 = in_x[W-1] ? XMIN : XMAX;
    else           x2 = {in_x[W-2:0], 1'b0};
    sat_abs = (x2 == XMIN);
    // upper bits of -x2 = ~hi + carry, the carry coming out of the dropped LSBs
    if (sat_abs)     s1_a = XMAX[W-1:2];
    else if (x2[W-1]) s1_a = ~x2[W-2:2] + {{(W-4){1'b0}}, (x2[1:0] == 2'b00)};
    else             s1_a = x2[W-2:2];
  end

  always_comb begin
    n    = a1_q[W-3:FW-2];
    base = HALF - {2'b00, a1_q[FW-3:0]};
    s2_t = (int'(n) >= FW) ? '0 : (base >> n);
  end

  always_comb begin
    if (tag2_q.neg)        s = t2_q;
    else if (t2_q == '0)   s = '1;
    else                   s = -t2_q;
    s3_y = tag2_q.mode ? ({s, 1'b0} - {1'b1, {FW{1'b0}}}) : {1'b0, s};
  end

  always_comb begin
    vld_d   = vld_q;
    a1_d    = a1_q;
    tag1_d  = tag1_q;
    t2_d    = t2_q;
    tag2_d  = tag2_q;
    y3_d    = y3_q;
    clip3_d = clip3_q;
    if (ld[1]) begin
      vld_d[1] = in_valid;
      if (in_valid) begin
        a1_d   = s1_a;
        tag1_d = '{mode: in_mode, neg: x2[W-1], clip: sat2 || sat_abs};
      end
    end
    if (ld[2]) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) begin
        t2_d   = s2_t;
        tag2_d = tag1_q;
      end
    end
    if (ld[3]) begin
      vld_d[3] = vld_q[2];
      if (vld_q[2]) begin
        y3_d    = s3_y;
        clip3_d = tag2_q.clip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      a1_q    <= '0;
      tag1_q  <= '0;
      t2_q    <= '0;
      tag2_q  <= '0;
      y3_q    <= '0;
      clip3_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      a1_q    <= a1_d;
      tag1_q  <= tag1_d;
      t2_q    <= t2_d;
      tag2_q  <= tag2_d;
      y3_q    <= y3_d;
      clip3_q <= clip3_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Directed bench for sigmoid_pwl_pipe (IW=FW=8): points, saturation, tanh,
// backpressure, bubble collapse, enable freeze and asynchronous reset.
module tb_sigmoid_pwl_pipe;
  logic        clk = 1'b0;
  logic        rst_n, ena, in_valid, in_ready, in_mode;
  logic        out_valid, out_ready, out_clip;
  logic [15:0] in_x;
  logic [8:0]  out_y;

  int          n_chk = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] bp_x [10];
  logic [8:0]  bp_y [10];

  sigmoid_pwl_pipe #(.IW(8), .FW(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_clip(out_clip)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] x, input logic m);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_mode = m;
    #1 chk("push_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic run_pt(input string tag, input logic [15:0] x, input logic m,
                        input logic [8:0] ey, input logic ec);
    push(x, m);
    @(negedge clk); in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(out_y), 32'(ey));
    chk({tag, "_clip"}, 32'(out_clip), 32'(ec));
  endtask

  // called just after a negedge with out_ready=1; pops exp_q per result
  task automatic drain(input string tag, input int n);
    int got = 0;
    int extra = 0;
    for (int c = 0; c < 20 && got < n; c++) begin
      #1;
      if (out_valid) begin
        chk(tag, 32'(out_y), 32'(exp_q.pop_front()));
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_cnt"}, 32'(got), 32'(n));
    for (int c = 0; c < 4; c++) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    chk({tag, "_extra"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int sent, recv, cnt, extra;
    logic acc, del;
    bp_x = '{16'h0000, 16'h0080, 16'h0100, 16'hFF00, 16'h0200,
             16'hFE00, 16'h0040, 16'hFFC0, 16'h0300, 16'hFD00};
    bp_y = '{9'h080, 9'h0A0, 9'h0C0, 9'h040, 9'h0E0,
             9'h020, 9'h090, 9'h070, 9'h0F0, 9'h010};
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_clip", 32'(out_clip), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_pt("sig_0",    16'h0000, 1'b0, 9'h080, 1'b0);
    run_pt("sig_half", 16'h0080, 1'b0, 9'h0A0, 1'b0);
    run_pt("sig_1",    16'h0100, 1'b0, 9'h0C0, 1'b0);
    run_pt("sig_m1",   16'hFF00, 1'b0, 9'h040, 1'b0);
    run_pt("sig_max",  16'h7FFF, 1'b0, 9'h0FF, 1'b0);
    run_pt("sig_min",  16'h8000, 1'b0, 9'h000, 1'b1);
    run_pt("sig_n8",   16'h0800, 1'b0, 9'h0FF, 1'b0);
    run_pt("tanh_h",   16'h0080, 1'b1, 9'h080, 1'b0);
    run_pt("tanh_0",   16'h0000, 1'b1, 9'h000, 1'b0);
    run_pt("tanh_sp",  16'h4000, 1'b1, 9'h0FE, 1'b1);
    run_pt("tanh_sn",  16'hC000, 1'b1, 9'h100, 1'b1);

    // backpressure: bench tracks occupancy; 3 in flight means every stage is full
    sent = 0; recv = 0; cnt = 0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_x      = bp_x[(sent < 10) ? sent : 0];
      in_mode   = 1'b0;
      #1 chk("bp_rdy", 32'(in_ready), 32'(!(cnt == 3 && !out_ready)));
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) chk("bp_y", 32'(out_y), 32'(bp_y[recv]));
      @(posedge clk);
      sent += int'(acc); recv += int'(del);
      cnt = cnt + int'(acc) - int'(del);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_cnt", 32'(recv), 32'd10);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    chk("bp_extra", 32'(extra), 32'd0);

    // bubble collapse behind a stalled S3
    out_ready = 1'b0;
    push(16'h0080, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    push(16'h0200, 1'b0);
    push(16'hFE00, 1'b0);
    @(negedge clk); in_x = 16'h0300;
    #1 chk("bub_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1 chk("bub_hold", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h0E0); exp_q.push_back(9'h020);
    drain("bub_y", 3);

    // enable freeze with three samples in flight
    push(16'h0000, 1'b0);
    push(16'h0100, 1'b0);
    push(16'hFF00, 1'b0);
    @(negedge clk); in_valid = 1'b0; ena = 1'b0;
    #1 chk("ena_vld", 32'(out_valid), 32'd0);
    chk("ena_rdy", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("ena_vld_h", 32'(out_valid), 32'd0);
      chk("ena_y_h", 32'(out_y), 32'h080);
    end
    @(negedge clk); ena = 1'b1;
    exp_q.push_back(9'h080); exp_q.push_back(9'h0C0); exp_q.push_back(9'h040);
    drain("ena_y", 3);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    push(16'h0000, 1'b0);
    push(16'h8000, 1'b0);
    push(16'h0100, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("mrst_pre", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_y", 32'(out_y), 32'd0);
    chk("mrst_clip", 32'(out_clip), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("mrst_rdy", 32'(in_ready), 32'd1);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (out_valid) extra++;
    end
    chk("mrst_stale", 32'(extra), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
